// File: rtl/mem_unit_pkg.sv
// Shared types for the memory execution unit: unit selector, operand bundle,
// mem_ctrl field layout and the access FSM states.
package mem_unit_pkg;

    typedef enum logic [1:0] {
        UNIT_SEL_NONE = 2'd0,
        UNIT_SEL_ALU  = 2'd1,
        UNIT_SEL_MEM  = 2'd2
    } unit_sel_t;

    typedef logic [31:0] word_t;
    typedef word_t [2:0] unit_in_t;

    localparam int MEM_CTRL_SIZE_LSB     = 0;
    localparam int MEM_CTRL_SIZE_MSB     = 1;
    localparam int MEM_CTRL_UNSIGNED_BIT = 2;
    localparam int MEM_CTRL_WRITE_BIT    = 3;

    localparam logic [1:0] MEM_CTRL_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_CTRL_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_CTRL_SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} mem_state_t;

    // Size 3 is folded into word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_CTRL_SIZE_BYTE: size_bytes = 3'd1;
            MEM_CTRL_SIZE_HALF: size_bytes = 3'd2;
            default:            size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte strobes and write data for both beats,
// and the shifted, extended load result from the two captured read words.
module mem_lane_align
    import mem_unit_pkg::*;
(
    input  logic [3:0] ctrl,
    input  logic [1:0] o,
    input  word_t      wdata,
    input  word_t      rdata0,
    input  word_t      rdata1,
    output logic [3:0] wstrb0,
    output logic [3:0] wstrb1,
    output word_t      wdata0,
    output word_t      wdata1,
    output word_t      load_data
);

    logic [1:0]  size;
    logic        is_unsigned;
    logic [3:0]  m;
    logic [7:0]  s;
    logic [63:0] d;
    logic [63:0] r;

    always_comb begin
        size        = ctrl[MEM_CTRL_SIZE_MSB:MEM_CTRL_SIZE_LSB];
        is_unsigned = ctrl[MEM_CTRL_UNSIGNED_BIT];
        case (size)
            MEM_CTRL_SIZE_BYTE: m = 4'h1;
            MEM_CTRL_SIZE_HALF: m = 4'h3;
            default:            m = 4'hF;
        endcase
        s = {4'b0, m} << o;
        d = {32'b0, wdata} << {o, 3'b000};
        r = {rdata1, rdata0} >> {o, 3'b000};

        wstrb0 = s[3:0];
        wstrb1 = s[7:4];
        wdata0 = d[31:0];
        wdata1 = d[63:32];

        case (size)
            MEM_CTRL_SIZE_BYTE: load_data = is_unsigned ? {24'b0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
            MEM_CTRL_SIZE_HALF: load_data = is_unsigned ? {16'b0, r[15:0]} : {{16{r[15]}}, r[15:0]};
            default:            load_data = r[31:0];
        endcase
    end

endmodule

// File: rtl/mem_unit.sv
// Memory execution unit: latches a request, runs one or two word-bus beats
// (two when the access straddles a word), returns load data or store completion.
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  unit_sel_t   unit_sel,
    input  unit_in_t    unit_in,
    output word_t       unit_out,
    output logic        unit_ready,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [29:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output word_t       bus_wdata,
    input  logic        bus_rsp_valid,
    input  word_t       bus_rdata,
    output logic        timeout
);

    localparam int WDW = $clog2(TIMEOUT + 2);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    mem_state_t     state, nxt;
    logic [3:0]     ctrl_q;
    word_t          addr_q, wdata_q, rdata0_q, rdata1_q;
    logic [WDW-1:0] wd_cnt;
    logic           to_q;

    logic           split, wd_expire, is_write, in_req;
    logic [3:0]     wstrb0, wstrb1;
    word_t          wdata0, wdata1, load_data;
    logic           unused_ctrl_hi;

    assign unused_ctrl_hi = ^unit_in[0][31:4];

    mem_lane_align u_align (
        .ctrl      (ctrl_q),
        .o         (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata0    (rdata0_q),
        .rdata1    (rdata1_q),
        .wstrb0    (wstrb0),
        .wstrb1    (wstrb1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .load_data (load_data)
    );

    assign split     = ({1'b0, addr_q[1:0]} + size_bytes(ctrl_q[1:0])) > 3'd4;
    assign is_write  = ctrl_q[MEM_CTRL_WRITE_BIT];
    // The watchdog fires on the cycle whose increment would reach TIMEOUT.
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST) && !bus_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (unit_sel == UNIT_SEL_MEM) nxt = REQ0;
            REQ0: if (bus_req_ready) nxt = RSP0;
            RSP0: if (bus_rsp_valid) nxt = split ? REQ1 : DONE;
                  else if (wd_expire) nxt = DONE;
            REQ1: if (bus_req_ready) nxt = RSP1;
            RSP1: if (bus_rsp_valid || wd_expire) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase

        in_req        = (state == REQ0) || (state == REQ1);
        bus_req_valid = in_req;
        bus_addr      = (state == REQ1) ? addr_q[31:2] + 30'd1 : addr_q[31:2];
        bus_we        = in_req && is_write;
        bus_wstrb     = 4'b0;
        bus_wdata     = '0;
        if (in_req && is_write) begin
            bus_wstrb = (state == REQ1) ? wstrb1 : wstrb0;
            bus_wdata = (state == REQ1) ? wdata1 : wdata0;
        end

        unit_ready = (state == DONE);
        timeout    = (state == DONE) && to_q;
        unit_out   = '0;
        if (state == DONE) begin
            if (to_q)          unit_out = 32'hDEAD_BEEF;
            else if (!is_write) unit_out = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            wd_cnt   <= '0;
            to_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (unit_sel == UNIT_SEL_MEM) begin
                    ctrl_q   <= unit_in[0][3:0];
                    addr_q   <= unit_in[1];
                    wdata_q  <= unit_in[2];
                    rdata0_q <= '0;
                    rdata1_q <= '0;
                    to_q     <= 1'b0;
                end
                REQ0, REQ1: wd_cnt <= '0;
                RSP0: begin
                    if (bus_rsp_valid)  rdata0_q <= bus_rdata;
                    else if (wd_expire) to_q     <= 1'b1;
                    else                wd_cnt   <= wd_cnt + WDW'(1);
                end
                RSP1: begin
                    if (bus_rsp_valid)  rdata1_q <= bus_rdata;
                    else if (wd_expire) to_q     <= 1'b1;
                    else                wd_cnt   <= wd_cnt + WDW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
